// File: rtl/score_decoder.sv
// Converts N_DIGITS active-low 7-segment digits into a binary value via reverse double-dabble.
// Optional macro SCORE_DECODER_ERR_EN adds an error output that flags unrecognised segment patterns.
module score_decoder #(
  parameter int N_DIGITS      = 2,
  parameter int OUTPUT_LENGTH = 7
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [7*N_DIGITS-1:0]    segments,
  input  logic                     start,
  output logic [OUTPUT_LENGTH-1:0] binary,
  output logic                     busy,
  output logic                     completed
`ifdef SCORE_DECODER_ERR_EN
  ,
  output logic                     error
`endif
);

  localparam int W  = 4 * N_DIGITS;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    SHIFT,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [7*N_DIGITS-1:0]    seg_reg;
  logic [W-1:0]             bcd;
  logic [W-1:0]             bin;
  logic [CW-1:0]            cnt;
  logic [W-1:0]             dec_bcd;
  logic [W-1:0]             bcd_sh;
  logic [W-1:0]             bin_sh;
  logic [OUTPUT_LENGTH-1:0] bin_trunc;
  logic                     accept;
`ifdef SCORE_DECODER_ERR_EN
  logic                     dec_invalid;
  logic                     err_flag;
`endif

  function automatic logic [3:0] decode_digit(input logic [6:0] pattern);
    logic [3:0] value;
    value = 4'd0;
    case (pattern)
      7'h40:   value = 4'd0;
      7'h79:   value = 4'd1;
      7'h24:   value = 4'd2;
      7'h30:   value = 4'd3;
      7'h19:   value = 4'd4;
      7'h12:   value = 4'd5;
      7'h02:   value = 4'd6;
      7'h78:   value = 4'd7;
      7'h00:   value = 4'd8;
      7'h10:   value = 4'd9;
      default: value = 4'd0;
    endcase
    return value;
  endfunction

`ifdef SCORE_DECODER_ERR_EN
  function automatic logic digit_valid(input logic [6:0] pattern);
    return pattern inside {7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                           7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  endfunction
`endif

  // A start arriving alongside the completion pulse belongs to the finished job and is dropped.
  assign accept = start && !completed;
  assign busy   = (state != IDLE);

  always_comb begin
    dec_bcd = '0;
`ifdef SCORE_DECODER_ERR_EN
    dec_invalid = 1'b0;
`endif
    for (int i = 0; i < N_DIGITS; i++) begin
      dec_bcd[4*i +: 4] = decode_digit(seg_reg[7*i +: 7]);
`ifdef SCORE_DECODER_ERR_EN
      if (!digit_valid(seg_reg[7*i +: 7])) dec_invalid = 1'b1;
`endif
    end
  end

  // One reverse double-dabble step: shift right, then correct any BCD digit that reached 8 or more.
  always_comb begin
    {bcd_sh, bin_sh} = {bcd, bin} >> 1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (bcd_sh[4*i +: 4] >= 4'd8) bcd_sh[4*i +: 4] = bcd_sh[4*i +: 4] - 4'd3;
    end
  end

  always_comb begin
    bin_trunc = '0;
    for (int i = 0; i < OUTPUT_LENGTH && i < W; i++) bin_trunc[i] = bin[i];
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (accept) state_next = DECODE;
`ifdef SCORE_DECODER_ERR_EN
      DECODE: state_next = dec_invalid ? DONE : SHIFT;
`else
      DECODE: state_next = SHIFT;
`endif
      SHIFT:  if (cnt == CW'(W - 1)) state_next = DONE;
      DONE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and registered outputs follow the state register; completed is a one-cycle pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      seg_reg   <= '0;
      bcd       <= '0;
      bin       <= '0;
      cnt       <= '0;
      binary    <= '0;
      completed <= 1'b0;
`ifdef SCORE_DECODER_ERR_EN
      err_flag  <= 1'b0;
      error     <= 1'b0;
`endif
    end else begin
      completed <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) seg_reg <= segments;
        end
        DECODE: begin
          bcd <= dec_bcd;
          bin <= '0;
          cnt <= '0;
`ifdef SCORE_DECODER_ERR_EN
          err_flag <= dec_invalid;
`endif
        end
        SHIFT: begin
          bcd <= bcd_sh;
          bin <= bin_sh;
          cnt <= cnt + CW'(1);
        end
        DONE: begin
          completed <= 1'b1;
`ifdef SCORE_DECODER_ERR_EN
          error <= err_flag;
          if (!err_flag) binary <= bin_trunc;
`else
          binary <= bin_trunc;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_score_decoder.sv
// Directed self-checking bench for score_decoder: conversion, latency, busy, restart, reset abort,
// invalid patterns and truncation (a second instance with OUTPUT_LENGTH=5).
module tb_score_decoder;

  logic        clock;
  logic        reset;
  logic [13:0] segments;
  logic        start;
  logic [6:0]  binary;
  logic        busy;
  logic        completed;
  logic [4:0]  binary_t;
  logic        busy_t;
  logic        completed_t;
`ifdef SCORE_DECODER_ERR_EN
  logic        error;
  logic        error_t;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  score_decoder #(.N_DIGITS(2), .OUTPUT_LENGTH(7)) dut (
    .clock(clock), .reset(reset), .segments(segments), .start(start),
    .binary(binary), .busy(busy), .completed(completed)
`ifdef SCORE_DECODER_ERR_EN
    , .error(error)
`endif
  );

  score_decoder #(.N_DIGITS(2), .OUTPUT_LENGTH(5)) dut_trunc (
    .clock(clock), .reset(reset), .segments(segments), .start(start),
    .binary(binary_t), .busy(busy_t), .completed(completed_t)
`ifdef SCORE_DECODER_ERR_EN
    , .error(error_t)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs are changed and outputs sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Pulses start with the given digits and waits (bounded) for completed; cycles=99 on timeout.
  task automatic run_conv(input logic [13:0] seg, output int cycles, output bit busy_ok);
    bit done;
    segments = seg;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    cycles   = 99;
    busy_ok  = (busy === 1'b1);
    done     = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (!done) begin
        tick();
        if (completed === 1'b1) begin
          cycles = i;
          done   = 1'b1;
          if (busy !== 1'b0) busy_ok = 1'b0;
        end else if (busy !== 1'b1) begin
          busy_ok = 1'b0;
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    segments = '0;
    tick();
    tick();
    n_checks++;
    if (binary !== 7'd0) begin n_fail++; $display("[TB] FAIL reset_binary got %0d expected 0", binary); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy got %b expected 0", busy); end
    n_checks++;
    if (completed !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_completed got %b expected 0", completed); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_convert();
    int cycles;
    bit busy_ok;
    run_conv({7'h19, 7'h24}, cycles, busy_ok);
    n_checks++;
    if (cycles !== 10) begin n_fail++; $display("[TB] FAIL latency_42 got %0d expected 10", cycles); end
    n_checks++;
    if (binary !== 7'd42) begin n_fail++; $display("[TB] FAIL value_42 got %0d expected 42", binary); end
    n_checks++;
    if (busy_ok !== 1'b1) begin n_fail++; $display("[TB] FAIL busy_42 got %b expected 1", busy_ok); end
    n_checks++;
    if (binary_t !== 5'd10) begin n_fail++; $display("[TB] FAIL trunc_42 got %0d expected 10", binary_t); end
    tick();
    n_checks++;
    if (completed !== 1'b0) begin n_fail++; $display("[TB] FAIL pulse_width got %b expected 0", completed); end
    segments = {7'h79, 7'h78};
    repeat (5) tick();
    n_checks++;
    if (binary !== 7'd42) begin n_fail++; $display("[TB] FAIL hold_42 got %0d expected 42", binary); end

    run_conv({7'h10, 7'h10}, cycles, busy_ok);
    n_checks++;
    if (binary !== 7'b1100011) begin n_fail++; $display("[TB] FAIL value_99 got %0d expected 99", binary); end
    n_checks++;
    if (binary_t !== 5'd3) begin n_fail++; $display("[TB] FAIL trunc_99 got %0d expected 3", binary_t); end
    tick();

    run_conv({7'h40, 7'h40}, cycles, busy_ok);
    n_checks++;
    if (binary !== 7'd0) begin n_fail++; $display("[TB] FAIL value_00 got %0d expected 0", binary); end
    n_checks++;
    if (cycles !== 10) begin n_fail++; $display("[TB] FAIL latency_00 got %0d expected 10", cycles); end
    tick();
  endtask

  task automatic test_restart();
    int pulses;
    segments = {7'h19, 7'h24};
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    segments = {7'h79, 7'h78};
    start = 1'b1;
    tick();
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (completed === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses !== 1) begin n_fail++; $display("[TB] FAIL restart_pulses got %0d expected 1", pulses); end
    n_checks++;
    if (binary !== 7'd42) begin n_fail++; $display("[TB] FAIL restart_value got %0d expected 42", binary); end
  endtask

  task automatic test_back_to_back();
    int cycles;
    int pulses;
    bit busy_ok;
    run_conv({7'h19, 7'h24}, cycles, busy_ok);
    segments = {7'h10, 7'h10};
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL start_on_done_busy got %b expected 0", busy); end
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (completed === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses !== 0) begin n_fail++; $display("[TB] FAIL start_on_done_pulses got %0d expected 0", pulses); end
    n_checks++;
    if (binary !== 7'd42) begin n_fail++; $display("[TB] FAIL start_on_done_value got %0d expected 42", binary); end
  endtask

  task automatic test_reset_abort();
    int cycles;
    int pulses;
    bit busy_ok;
    segments = {7'h19, 7'h24};
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_busy got %b expected 0", busy); end
    n_checks++;
    if (binary !== 7'd0) begin n_fail++; $display("[TB] FAIL abort_binary got %0d expected 0", binary); end
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (completed === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses !== 0) begin n_fail++; $display("[TB] FAIL abort_pulses got %0d expected 0", pulses); end

    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_over_start got %b expected 0", busy); end

    run_conv({7'h40, 7'h78}, cycles, busy_ok);
    n_checks++;
    if (binary !== 7'd7) begin n_fail++; $display("[TB] FAIL after_abort_07 got %0d expected 7", binary); end
    tick();
  endtask

  task automatic test_invalid();
    int cycles;
    bit busy_ok;
    run_conv({7'h19, 7'h7F}, cycles, busy_ok);
`ifdef SCORE_DECODER_ERR_EN
    n_checks++;
    if (cycles !== 2) begin n_fail++; $display("[TB] FAIL invalid_latency got %0d expected 2", cycles); end
    n_checks++;
    if (error !== 1'b1) begin n_fail++; $display("[TB] FAIL invalid_error got %b expected 1", error); end
    n_checks++;
    if (binary !== 7'd7) begin n_fail++; $display("[TB] FAIL invalid_hold got %0d expected 7", binary); end
    tick();
    run_conv({7'h19, 7'h24}, cycles, busy_ok);
    n_checks++;
    if (error !== 1'b0) begin n_fail++; $display("[TB] FAIL valid_error got %b expected 0", error); end
    n_checks++;
    if (binary !== 7'd42) begin n_fail++; $display("[TB] FAIL valid_after_err got %0d expected 42", binary); end
`else
    n_checks++;
    if (cycles !== 10) begin n_fail++; $display("[TB] FAIL invalid_latency got %0d expected 10", cycles); end
    n_checks++;
    if (binary !== 7'd40) begin n_fail++; $display("[TB] FAIL invalid_as_zero got %0d expected 40", binary); end
`endif
    tick();
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    segments = '0;
    test_reset();
    test_convert();
    test_restart();
    test_back_to_back();
    test_reset_abort();
    test_invalid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
